camera_capture_ctrl: RTL and testbench

Frame-capture sequencer for the 8-bit camera source. Drives camera_en for exactly one frame of FRAME_LEN bytes and collects the valid-qualified camera bytes. Writes them into a downstream frame buffer through a simple write port (wr_en/wr_addr/wr_data). Supports single-shot and continuous capture, buffer-ready back-pressure, abort, and sticky error flags.

---
 rtl/camera_capture_ctrl.sv | 171 +++++++++++++++++
 tb/tb_camera_capture_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/camera_capture_ctrl.sv
// Frame-capture sequencer: enables the camera for one frame, writes the valid bytes
// into a frame buffer, and handles continuous mode, back-pressure, abort and error flags.
module camera_capture_ctrl #(
  parameter int FRAME_LEN     = 75,
  parameter int ADDR_W        = 7,
  parameter int GAP_CYCLES    = 4,
  parameter int DRAIN_TIMEOUT = 3,
  parameter int CNT_W         = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              continuous,
  input  logic              abort,
  input  logic              buf_ready,
  input  logic              cam_valid,
  input  logic [7:0]        cam_data,
  input  logic              clear_status,
  output logic              camera_en,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic [CNT_W-1:0]  frame_count,
  output logic              short_frame,
  output logic              stray_data
);

  localparam int TMR_MAX0 = (FRAME_LEN > GAP_CYCLES) ? FRAME_LEN : GAP_CYCLES;
  localparam int TMR_MAX  = (TMR_MAX0 > DRAIN_TIMEOUT) ? TMR_MAX0 : DRAIN_TIMEOUT;
  localparam int TMR_W    = $clog2(TMR_MAX + 1);

  typedef enum logic [2:0] {IDLE, WAIT_BUF, CAPTURE, DRAIN, GAP} state_t;

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [ADDR_W-1:0]  byte_q, byte_d;
  logic               camera_en_q, camera_en_d;
  logic               wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [7:0]         wr_data_q, wr_data_d;
  logic               frame_done_q, frame_done_d;
  logic [CNT_W-1:0]   frame_count_q, frame_count_d;
  logic               short_q, short_d;
  logic               stray_q, stray_d;
  logic               in_cap, take, last_take;

  always_comb begin
    state_d       = state_q;
    tmr_d         = tmr_q;
    byte_d        = byte_q;
    camera_en_d   = camera_en_q;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;
    short_d       = clear_status ? 1'b0 : short_q;
    stray_d       = clear_status ? 1'b0 : stray_q;

    in_cap    = (state_q == CAPTURE) || (state_q == DRAIN);
    take      = in_cap && cam_valid && !abort;
    last_take = take && (byte_q == ADDR_W'(FRAME_LEN - 1));

    // cam_data is only sampled under cam_valid in an active state, so Z never reaches wr_data
    if (take) begin
      wr_en_d   = 1'b1;
      wr_addr_d = byte_q;
      wr_data_d = cam_data;
      byte_d    = byte_q + 1'b1;
    end
    if (last_take) begin
      frame_done_d  = 1'b1;
      frame_count_d = frame_count_q + 1'b1;
    end
    if (cam_valid && !in_cap) stray_d = 1'b1;

    case (state_q)
      IDLE: if (start || continuous) state_d = WAIT_BUF;
      WAIT_BUF: begin
        if (buf_ready) begin
          state_d     = CAPTURE;
          camera_en_d = 1'b1;
          tmr_d       = '0;
          byte_d      = '0;
        end
      end
      CAPTURE: begin
        if (last_take) begin
          state_d     = GAP;
          camera_en_d = 1'b0;
          tmr_d       = '0;
        end else if (tmr_q == TMR_W'(FRAME_LEN - 1)) begin
          state_d     = DRAIN;
          camera_en_d = 1'b0;
          tmr_d       = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      DRAIN: begin
        if (last_take) begin
          state_d = GAP;
          tmr_d   = '0;
        end else if (tmr_q == TMR_W'(DRAIN_TIMEOUT - 1)) begin
          state_d = GAP;
          tmr_d   = '0;
          if (!abort) short_d = 1'b1;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      GAP: begin
        if (tmr_q == TMR_W'(GAP_CYCLES - 1)) begin
          state_d = continuous ? WAIT_BUF : IDLE;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d     = IDLE;
      camera_en_d = 1'b0;
      tmr_d       = '0;
      byte_d      = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      tmr_q         <= '0;
      byte_q        <= '0;
      camera_en_q   <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
      short_q       <= 1'b0;
      stray_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      tmr_q         <= tmr_d;
      byte_q        <= byte_d;
      camera_en_q   <= camera_en_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
      short_q       <= short_d;
      stray_q       <= stray_d;
    end
  end

  assign camera_en   = camera_en_q;
  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign busy        = (state_q != IDLE);
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;
  assign short_frame = short_q;
  assign stray_data  = stray_q;

endmodule

// File: tb/tb_camera_capture_ctrl.sv
// Directed bench for camera_capture_ctrl with a registered camera model driving
// a known 75-byte frame pattern.
module tb_camera_capture_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, continuous = 1'b0, abort = 1'b0, buf_ready = 1'b1;
  logic        clear_status = 1'b0;
  logic        cam_valid;
  logic [7:0]  cam_data;
  logic        camera_en, wr_en, busy, frame_done, short_frame, stray_data;
  logic [6:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [15:0] frame_count;

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;

  camera_capture_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous), .abort(abort),
    .buf_ready(buf_ready), .cam_valid(cam_valid), .cam_data(cam_data),
    .clear_status(clear_status), .camera_en(camera_en), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .frame_done(frame_done),
    .frame_count(frame_count), .short_frame(short_frame), .stray_data(stray_data)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] camdata(input int i);
    case (i)
      0:  camdata = 8'hBC;
      1:  camdata = 8'h27;
      2:  camdata = 8'h81;
      72: camdata = 8'hE1;
      73: camdata = 8'hFF;
      74: camdata = 8'hDE;
      default: camdata = 8'((i * 37 + 5) & 255);
    endcase
  endfunction

  // Camera model: one-cycle registered response to camera_en, index resets when disabled
  int         cam_idx = 0;
  int         cam_limit = 75;
  logic       cam_v_m = 1'b0;
  logic [7:0] cam_d_m = 8'hzz;
  logic       inj_valid = 1'b0;

  always @(posedge clk) begin
    if (camera_en) begin
      cam_v_m <= (cam_idx < cam_limit);
      cam_d_m <= camdata(cam_idx);
      cam_idx <= cam_idx + 1;
    end else begin
      cam_v_m <= 1'b0;
      cam_d_m <= 8'hzz;
      cam_idx <= 0;
    end
  end
  assign cam_valid = cam_v_m | inj_valid;
  assign cam_data  = cam_d_m;

  // Observation state gathered by collect()
  int   cyc, nwr, bad_wr, ndone, bad_done, nruns, bad_run, cur_run, low_run, min_gap, done_cyc;
  logic prev_en, seen_high;
  logic busy_hist [0:1023];

  task automatic clear_stats();
    cyc = 0; nwr = 0; bad_wr = 0; ndone = 0; bad_done = 0; nruns = 0; bad_run = 0;
    cur_run = 0; low_run = 0; min_gap = 1000; done_cyc = 0; prev_en = 1'b0; seen_high = 1'b0;
  endtask

  task automatic collect(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (camera_en) begin
        if (!prev_en && seen_high && low_run < min_gap) min_gap = low_run;
        cur_run++; seen_high = 1'b1; low_run = 0;
      end else begin
        if (prev_en) begin
          nruns++;
          if (cur_run != 75) bad_run++;
        end
        cur_run = 0; low_run++;
      end
      prev_en = camera_en;
      if (wr_en) begin
        if (wr_addr !== 7'(nwr % 75) || wr_data !== camdata(nwr % 75)) bad_wr++;
        nwr++;
      end
      if (frame_done) begin
        ndone++;
        if (!(wr_en && wr_addr == 7'd74)) bad_done++;
        done_cyc = cyc;
      end
      if (cyc < 1024) busy_hist[cyc] = busy;
      cyc++;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({camera_en, wr_en, busy, frame_done, short_frame, stray_data, wr_addr, wr_data, frame_count} !== '0) begin
      errors++; $display("FAIL reset_outputs: got non-zero outputs, want all 0");
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    clear_stats();
    pulse_start();
    collect(100);
    exp_cnt++;
    checks++; if (nruns !== 1 || bad_run !== 0) begin errors++; $display("FAIL single_en_runs: runs=%0d bad=%0d want 1/0", nruns, bad_run); end
    checks++; if (nwr !== 75) begin errors++; $display("FAIL single_writes: got %0d want 75", nwr); end
    checks++; if (bad_wr !== 0) begin errors++; $display("FAIL single_addr_data: %0d bad writes want 0", bad_wr); end
    checks++; if (ndone !== 1 || bad_done !== 0) begin errors++; $display("FAIL single_done: done=%0d misplaced=%0d want 1/0", ndone, bad_done); end
    checks++; if (frame_count !== 16'(exp_cnt)) begin errors++; $display("FAIL single_count: got %0d want %0d", frame_count, exp_cnt); end
    checks++; if (busy_hist[done_cyc+3] !== 1'b1 || busy_hist[done_cyc+4] !== 1'b0) begin
      errors++; $display("FAIL single_gap_busy: busy@+3=%b busy@+4=%b want 1/0", busy_hist[done_cyc+3], busy_hist[done_cyc+4]);
    end
  endtask

  task automatic test_continuous();
    clear_stats();
    @(negedge clk); continuous = 1'b1;
    collect(200);
    continuous = 1'b0;
    collect(120);
    exp_cnt += 3;
    checks++; if (nruns !== 3 || bad_run !== 0) begin errors++; $display("FAIL cont_en_runs: runs=%0d bad=%0d want 3/0", nruns, bad_run); end
    checks++; if (nwr !== 225 || bad_wr !== 0) begin errors++; $display("FAIL cont_writes: n=%0d bad=%0d want 225/0", nwr, bad_wr); end
    checks++; if (ndone !== 3 || bad_done !== 0) begin errors++; $display("FAIL cont_done: done=%0d misplaced=%0d want 3/0", ndone, bad_done); end
    checks++; if (min_gap < 4) begin errors++; $display("FAIL cont_gap: min low gap %0d want >=4", min_gap); end
    checks++; if (frame_count !== 16'(exp_cnt)) begin errors++; $display("FAIL cont_count: got %0d want %0d", frame_count, exp_cnt); end
    checks++; if ({short_frame, stray_data, busy} !== 3'b000) begin errors++; $display("FAIL cont_flags: short/stray/busy=%b%b%b want 000", short_frame, stray_data, busy); end
  endtask

  task automatic test_back_pressure();
    int bad = 0;
    buf_ready = 1'b0;
    pulse_start();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (camera_en || wr_en) bad++;
    end
    checks++; if (bad !== 0 || busy !== 1'b1) begin errors++; $display("FAIL bp_wait: active=%0d busy=%b want 0/1", bad, busy); end
    buf_ready = 1'b1;
    @(negedge clk);
    checks++; if (camera_en !== 1'b1) begin errors++; $display("FAIL bp_release: camera_en=%b want 1", camera_en); end
    buf_ready = 1'b0;
    clear_stats(); cur_run = 1; prev_en = 1'b1; seen_high = 1'b1;
    collect(100);
    buf_ready = 1'b1;
    exp_cnt++;
    checks++; if (nwr !== 75 || bad_wr !== 0 || bad_run !== 0) begin errors++; $display("FAIL bp_frame: n=%0d bad=%0d badrun=%0d want 75/0/0", nwr, bad_wr, bad_run); end
    checks++; if (ndone !== 1 || frame_count !== 16'(exp_cnt)) begin errors++; $display("FAIL bp_done: done=%0d count=%0d want 1/%0d", ndone, frame_count, exp_cnt); end
  endtask

  task automatic test_abort();
    logic found = 1'b0;
    int   bad = 0;
    pulse_start();
    for (int k = 0; k < 150 && !found; k++) begin
      @(negedge clk);
      if (wr_en && wr_addr == 7'd30) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL abort_wait: addr 30 write not seen within budget"); end
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    checks++; if (camera_en !== 1'b0 || busy !== 1'b0 || wr_en !== 1'b0) begin
      errors++; $display("FAIL abort_stop: en=%b busy=%b wr=%b want 000", camera_en, busy, wr_en);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (wr_en || frame_done) bad++;
    end
    checks++; if (bad !== 0 || frame_count !== 16'(exp_cnt)) begin errors++; $display("FAIL abort_quiet: activity=%0d count=%0d want 0/%0d", bad, frame_count, exp_cnt); end
    @(negedge clk); clear_status = 1'b1;
    @(negedge clk); clear_status = 1'b0;
    clear_stats();
    pulse_start();
    collect(100);
    exp_cnt++;
    checks++; if (nwr !== 75 || bad_wr !== 0 || ndone !== 1) begin errors++; $display("FAIL abort_restart: n=%0d bad=%0d done=%0d want 75/0/1", nwr, bad_wr, ndone); end
    checks++; if (frame_count !== 16'(exp_cnt)) begin errors++; $display("FAIL abort_count: got %0d want %0d", frame_count, exp_cnt); end
  endtask

  task automatic test_short_frame();
    cam_limit = 70;
    clear_stats();
    pulse_start();
    collect(100);
    cam_limit = 75;
    checks++; if (nwr !== 70 || bad_wr !== 0 || ndone !== 0) begin errors++; $display("FAIL short_writes: n=%0d bad=%0d done=%0d want 70/0/0", nwr, bad_wr, ndone); end
    checks++; if (short_frame !== 1'b1 || stray_data !== 1'b0) begin errors++; $display("FAIL short_flag: short=%b stray=%b want 1/0", short_frame, stray_data); end
    checks++; if (frame_count !== 16'(exp_cnt)) begin errors++; $display("FAIL short_count: got %0d want %0d", frame_count, exp_cnt); end
    clear_status = 1'b1;
    @(negedge clk); clear_status = 1'b0;
    checks++; if (short_frame !== 1'b0) begin errors++; $display("FAIL short_clear: short=%b want 0", short_frame); end
  endtask

  task automatic test_reset_stray();
    pulse_start();
    repeat (30) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({camera_en, wr_en, busy, frame_done, short_frame, stray_data, wr_addr, wr_data, frame_count} !== '0) begin
      errors++; $display("FAIL midframe_reset: en=%b wr=%b busy=%b count=%0d want all 0", camera_en, wr_en, busy, frame_count);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
    @(negedge clk); inj_valid = 1'b1;
    @(negedge clk); inj_valid = 1'b0;
    checks++; if (stray_data !== 1'b1 || wr_en !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL stray: stray=%b wr=%b busy=%b want 1/0/0", stray_data, wr_en, busy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_continuous();
    test_back_pressure();
    test_abort();
    test_short_frame();
    test_reset_stray();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
